// File: rtl/vt52_pkg.sv
// Shared definitions for the VT52 terminal datapath: XON/XOFF bytes and the
// host flow-control state encoding.
package vt52_pkg;

  localparam logic [7:0] XON_BYTE  = 8'h11;
  localparam logic [7:0] XOFF_BYTE = 8'h13;

  typedef enum logic [1:0] {
    FLOWING   = 2'd0,
    SEND_XOFF = 2'd1,
    STOPPED   = 2'd2,
    SEND_XON  = 2'd3
  } flow_state_t;

  // The control byte a state is trying to send (only meaningful in SEND_* states).
  function automatic logic [7:0] ctrl_byte(input flow_state_t s);
    if (s == SEND_XOFF) begin
      return XOFF_BYTE;
    end else begin
      return XON_BYTE;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with an explicit occupancy counter, so level is
// exact at both empty and full without pointer-wrap ambiguity.
module sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == {LVL_W{1'b0}});
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage is not reset; only pointers and level carry state that matters.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_level  <= {LVL_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/flow_control_buffer.sv
// Host receive buffer with XON/XOFF flow control, merging control bytes into the
// keyboard byte stream heading back to the host.
module flow_control_buffer
  import vt52_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int HIGH_WATER = 48,
  parameter int LOW_WATER  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_rx_ready,
  output logic [7:0]             o_cmd_data,
  output logic                   o_cmd_valid,
  input  logic                   i_cmd_ready,
  input  logic [7:0]             i_kbd_data,
  input  logic                   i_kbd_valid,
  output logic                   o_kbd_ready,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_stopped
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] HIGH_LVL = LVL_W'(HIGH_WATER);
  localparam logic [LVL_W-1:0] LOW_LVL  = LVL_W'(LOW_WATER);

  logic [LVL_W-1:0] w_level;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_fifo_rdata;
  logic             w_rx_push;
  logic             w_cmd_pop;
  logic             w_tx_accept;
  logic             w_tx_can_load;
  logic             w_ctrl_pending;
  logic             w_kbd_load;

  flow_state_t      r_state;
  logic             r_stopped;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_tx_is_ctrl;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_reset_n),
    .i_push  (w_rx_push),
    .i_wdata (i_rx_data),
    .i_pop   (w_cmd_pop),
    .o_rdata (w_fifo_rdata),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_rx_ready  = !w_full;
  assign o_cmd_valid = !w_empty;
  assign o_cmd_data  = w_fifo_rdata;
  assign o_level     = w_level;
  assign w_rx_push   = i_rx_valid && o_rx_ready;
  assign w_cmd_pop   = o_cmd_valid && i_cmd_ready;

  // A control byte is owed until it sits in the tx register; once loaded it
  // only needs acceptance, so the keyboard may queue behind it.
  assign w_tx_accept    = r_tx_valid && i_tx_ready;
  assign w_tx_can_load  = !r_tx_valid || i_tx_ready;
  assign w_ctrl_pending = ((r_state == SEND_XOFF) || (r_state == SEND_XON)) && !r_tx_is_ctrl;
  assign o_kbd_ready    = w_tx_can_load && !w_ctrl_pending;
  assign w_kbd_load     = i_kbd_valid && o_kbd_ready;

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_stopped  = r_stopped;

  // Flow-control FSM; a requested XON/XOFF is never withdrawn once entered.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= FLOWING;
      r_stopped <= 1'b0;
    end else begin
      case (r_state)
        FLOWING: begin
          if (w_level >= HIGH_LVL) begin
            r_state <= SEND_XOFF;
          end
        end
        SEND_XOFF: begin
          if (w_tx_accept && r_tx_is_ctrl) begin
            r_state   <= STOPPED;
            r_stopped <= 1'b1;
          end
        end
        STOPPED: begin
          if (w_level <= LOW_LVL) begin
            r_state <= SEND_XON;
          end
        end
        SEND_XON: begin
          if (w_tx_accept && r_tx_is_ctrl) begin
            r_state   <= FLOWING;
            r_stopped <= 1'b0;
          end
        end
        default: begin
          r_state   <= FLOWING;
          r_stopped <= 1'b0;
        end
      endcase
    end
  end

  // One-byte tx holding register: control byte wins over a new keyboard byte.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_tx_is_ctrl <= 1'b0;
    end else if (w_tx_can_load) begin
      if (w_ctrl_pending) begin
        r_tx_data    <= ctrl_byte(r_state);
        r_tx_valid   <= 1'b1;
        r_tx_is_ctrl <= 1'b1;
      end else if (w_kbd_load) begin
        r_tx_data    <= i_kbd_data;
        r_tx_valid   <= 1'b1;
        r_tx_is_ctrl <= 1'b0;
      end else begin
        r_tx_valid   <= 1'b0;
        r_tx_is_ctrl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flow_control_buffer.sv
// Directed and randomized bench for flow_control_buffer against a queue-based
// model of the receive buffer and of the host-visible XON/XOFF protocol.
module tb_flow_control_buffer;

  localparam int DEPTH = 64;
  localparam int HIGH  = 48;
  localparam int LOW   = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic       kbd_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [6:0] level;
  logic       stopped;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] data_q[$];
  logic [7:0] kbd_q[$];
  logic [7:0] tx_log[$];
  logic [7:0] cmd_log[$];
  bit         held;
  bit         xoff_last;
  int         maxlvl;
  int         minlvl;
  int         xoff_cnt;
  int         xon_cnt;
  bit         prev_hold;
  logic [7:0] prev_txd;
  bit         prev_kbd_hs;
  bit         kr_seen;

  flow_control_buffer #(
    .DEPTH      (DEPTH),
    .HIGH_WATER (HIGH),
    .LOW_WATER  (LOW)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_rx_ready  (rx_ready),
    .o_cmd_data  (cmd_data),
    .o_cmd_valid (cmd_valid),
    .i_cmd_ready (cmd_ready),
    .i_kbd_data  (kbd_data),
    .i_kbd_valid (kbd_valid),
    .o_kbd_ready (kbd_ready),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_level     (level),
    .o_stopped   (stopped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    data_q.delete();
    kbd_q.delete();
    held        = 1'b0;
    xoff_last   = 1'b0;
    maxlvl      = 0;
    minlvl      = 1000;
    prev_hold   = 1'b0;
    prev_kbd_hs = 1'b0;
  endtask

  function automatic int count_tx(input logic [7:0] b);
    int n = 0;
    foreach (tx_log[i]) if (tx_log[i] == b) n++;
    return n;
  endfunction

  // Classify a byte leaving on tx: keyboard stream first, else a protocol byte.
  task automatic handle_tx(input logic [7:0] b);
    tx_log.push_back(b);
    if (kbd_q.size() > 0 && b == kbd_q[0]) begin
      void'(kbd_q.pop_front());
    end else if (b == 8'h13) begin
      chk("xoff_alternation", 32'(xoff_last), 32'd0);
      chk("xoff_trigger", 32'(maxlvl >= HIGH), 32'd1);
      xoff_last = 1'b1;
      held      = 1'b1;
      minlvl    = 1000;
      xoff_cnt++;
    end else if (b == 8'h11) begin
      chk("xon_alternation", 32'(xoff_last), 32'd1);
      chk("xon_trigger", 32'(minlvl <= LOW), 32'd1);
      xoff_last = 1'b0;
      held      = 1'b0;
      maxlvl    = 0;
      xon_cnt++;
    end else begin
      chk("tx_unexpected", 32'(b), (kbd_q.size() > 0) ? 32'(kbd_q[0]) : 32'hFFFF_FFFF);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, observe handshakes.
  task automatic cycle(input bit rxv, input logic [7:0] rxd, input bit cr,
                       input bit kv, input logic [7:0] kd, input bit tr);
    bit rx_hs, cmd_hs, kbd_hs, tx_hs;
    logic [7:0] txb, cmdb;
    chk("level", 32'(level), 32'(data_q.size()));
    chk("rx_ready", 32'(rx_ready), 32'(data_q.size() < DEPTH));
    chk("cmd_valid", 32'(cmd_valid), 32'(data_q.size() > 0));
    if (data_q.size() > 0) chk("cmd_data", 32'(cmd_data), 32'(data_q[0]));
    chk("stopped", 32'(stopped), 32'(held));
    if (prev_hold) begin
      chk("tx_hold_valid", 32'(tx_valid), 32'd1);
      chk("tx_hold_data", 32'(tx_data), 32'(prev_txd));
    end
    if (prev_kbd_hs) chk("kbd_latency", 32'(tx_valid), 32'd1);
    if (data_q.size() > maxlvl) maxlvl = data_q.size();
    if (data_q.size() < minlvl) minlvl = data_q.size();
    rx_valid  = rxv;
    rx_data   = rxd;
    cmd_ready = cr;
    kbd_valid = kv;
    kbd_data  = kd;
    tx_ready  = tr;
    #1;
    rx_hs       = rxv && rx_ready;
    cmd_hs      = cmd_valid && cr;
    kbd_hs      = kv && kbd_ready;
    tx_hs       = tx_valid && tr;
    kr_seen     = kbd_ready;
    txb         = tx_data;
    cmdb        = cmd_data;
    prev_hold   = tx_valid && !tr;
    prev_txd    = tx_data;
    prev_kbd_hs = kbd_hs;
    @(posedge clk);
    if (cmd_hs) begin
      cmd_log.push_back(cmdb);
      void'(data_q.pop_front());
    end
    if (rx_hs) data_q.push_back(rxd);
    if (kbd_hs) kbd_q.push_back(kd);
    if (tx_hs) handle_tx(txb);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cmd_ready = 1'b0;
    kbd_valid = 1'b0; kbd_data = 8'h00; tx_ready = 1'b0;
    xoff_cnt = 0; xon_cnt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_stopped", 32'(stopped), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_kbd_ready", 32'(kbd_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Five bytes straight through with the consumer always ready.
    cmd_log.delete();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h41 + i), 1'b1, 1'b0, 8'h00, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("t035_count", 32'(cmd_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("t035_order", 32'(cmd_log[i]), 32'(8'h41 + i));
    chk("t035_level", 32'(level), 32'd0);

    // Fill to the high-water mark, then to full.
    tx_log.delete();
    for (int i = 0; i < HIGH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (5) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t036_xoff_once", 32'(count_tx(8'h13)), 32'd1);
    chk("t036_stopped", 32'(stopped), 32'd1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t036_full_level", 32'(level), 32'd64);
    chk("t036_rx_ready", 32'(rx_ready), 32'd0);

    // Drain to the low-water mark.
    tx_log.delete();
    for (int i = 0; i < DEPTH - LOW; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    repeat (5) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t037_xon_once", 32'(count_tx(8'h11)), 32'd1);
    chk("t037_stopped", 32'(stopped), 32'd0);
    chk("t037_level", 32'(level), 32'd16);
    for (int i = 0; i < LOW; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);

    // Keyboard byte stuck in tx while the buffer reaches high water.
    tx_log.delete();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b0);
    for (int i = 0; i < HIGH; i++) begin
      cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1, 8'h62, 1'b0);
      chk("t038_kbd_blocked", 32'(kr_seen), 32'd0);
    end
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h62, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h62, 1'b1);
    chk("t038_ctrl_priority", 32'(kr_seen), 32'd0);
    repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t038_tx_count", 32'(tx_log.size()), 32'd2);
    chk("t038_first", 32'(tx_log[0]), 32'h61);
    chk("t038_second", 32'(tx_log[1]), 32'h13);

    // Keyboard XON/XOFF values are data only; the host stays held off.
    tx_log.delete();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h13, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t030_passthru_cnt", 32'(tx_log.size()), 32'd2);
    chk("t030_passthru_0", 32'(tx_log[0]), 32'h11);
    chk("t030_passthru_1", 32'(tx_log[1]), 32'h13);
    chk("t030_still_stopped", 32'(stopped), 32'd1);

    // Reset mid-operation at level 30 with a byte waiting on tx.
    for (int i = 0; i < 18; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0);
    chk("t039_pre_level", 32'(level), 32'd30);
    chk("t039_pre_tx_valid", 32'(tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t039_level", 32'(level), 32'd0);
    chk("t039_tx_valid", 32'(tx_valid), 32'd0);
    chk("t039_tx_data", 32'(tx_data), 32'd0);
    chk("t039_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("t039_stopped", 32'(stopped), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t039_post_valid", 32'(cmd_valid), 32'd1);
    chk("t039_post_data", 32'(cmd_data), 32'h77);

    // Random concurrent traffic with alternating fill and drain phases.
    xoff_cnt = 0;
    xon_cnt  = 0;
    cmd_log.delete();
    for (int c = 0; c < 10000; c++) begin
      bit fill;
      fill = ((c / 500) % 2) == 0;
      cycle($urandom_range(0, 99) < (fill ? 80 : 20),
            8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < (fill ? 20 : 80),
            $urandom_range(0, 99) < 30,
            8'($urandom_range(8'h20, 8'h7E)),
            $urandom_range(0, 99) < 70);
    end
    chk("rand_xoff_seen", 32'(xoff_cnt > 0), 32'd1);
    chk("rand_xon_seen", 32'(xon_cnt > 0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flow_control_buffer.md
FLOW_CONTROL_BUFFER -- requirements
Module: flow_control_buffer

Interface
REQ-001 Parameter DEPTH, default 64, meaning receive FIFO entries; power of two, at least 8.
REQ-002 Parameter HIGH_WATER, default 48, meaning fill level that triggers XOFF.
REQ-003 Parameter LOW_WATER, default 16, meaning fill level that triggers XON; LOW_WATER < HIGH_WATER <= DEPTH.
REQ-004 clk  input  1  single clock (48 MHz USB/VGA domain); all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx_data/rx_valid/rx_ready  in/in/out  8/1/1  host bytes from usb_uart uart_out.
REQ-007 cmd_data/cmd_valid/cmd_ready  out/out/in  8/1/1  buffered bytes to command_handler.
REQ-008 kbd_data/kbd_valid/kbd_ready  in/in/out  8/1/1  key bytes from keyboard.
REQ-009 tx_data/tx_valid/tx_ready  out/out/in  8/1/1  merged bytes to usb_uart uart_in.
REQ-010 level  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-011 stopped  output  1  high while host is held off by XOFF.

Function
REQ-012 All handshakes SHALL transfer a byte only on a cycle with valid and ready both high.
REQ-013 rx_ready SHALL be high exactly when level < DEPTH; bytes are never dropped.
REQ-014 cmd_valid SHALL be high exactly when level > 0; cmd_data is the oldest entry (show-ahead).
REQ-015 A byte accepted on rx SHALL appear on cmd no earlier than the next cycle; no same-cycle pass-through.
REQ-016 Simultaneous push and pop SHALL leave level unchanged; push at full and pop at empty are impossible by REQ-013/014.
REQ-017 Pointers SHALL wrap modulo DEPTH; level is computed without wrap error at 0 and DEPTH.
REQ-018 rx and cmd bytes SHALL pass unmodified, including 8'h11/8'h13 from the host.
REQ-019 Flow FSM states: FLOWING, SEND_XOFF, STOPPED, SEND_XON; reset state FLOWING.
REQ-020 FLOWING -> SEND_XOFF when level >= HIGH_WATER.
REQ-021 SEND_XOFF -> STOPPED on the cycle the XOFF byte (8'h13) is accepted on tx.
REQ-022 STOPPED -> SEND_XON when level <= LOW_WATER.
REQ-023 SEND_XON -> FLOWING on the cycle the XON byte (8'h11) is accepted on tx.
REQ-024 A pending control byte SHALL be sent even if level has since crossed back; no cancellation.
REQ-025 stopped SHALL be high in SEND_XOFF-accepted-onward states STOPPED and SEND_XON only.
REQ-026 tx output is a one-byte register: it loads when empty or accepted that cycle.
REQ-027 Load priority: pending control byte over keyboard byte; a keyboard byte already in the register is never preempted.
REQ-028 kbd_ready SHALL be high only when the tx register can load and no control byte is pending.
REQ-029 tx_data SHALL be stable while tx_valid is high and tx_ready low; latency kbd accept -> tx_valid is 1 cycle.
REQ-030 Keyboard bytes 8'h11/8'h13 SHALL pass through without affecting the FSM.

Reset
REQ-031 Reset low SHALL immediately clear pointers, level, tx_valid, cmd_valid, stopped, tx_data to 0 and FSM to FLOWING, mid-transfer included.
REQ-032 FIFO storage contents need not be cleared.

Structure
REQ-033 XON/XOFF byte constants and FSM state encoding SHALL live in shared package vt52_pkg.
REQ-034 FIFO storage and pointers SHALL be one sub-module, sync_fifo, parameterised by DEPTH and width 8.

Verification
REQ-035 Push 5 bytes 8'h41..8'h45, cmd_ready high -> same order on cmd, level returns to 0.
REQ-036 cmd_ready low, push 48 bytes -> tx emits 8'h13 once, stopped high; push 16 more -> rx_ready low at level 64.
REQ-037 From stopped at 64, drain to 16 -> tx emits 8'h11 once, stopped low.
REQ-038 tx_ready low holding key 8'h61 while level hits 48 -> 8'h61 sent first, then 8'h13; kbd_ready low meanwhile.
REQ-039 Reset pulsed with level 30 and tx_valid high -> all outputs 0, FSM FLOWING, next push appears normally.
REQ-040 Random concurrent rx/cmd/kbd/tx traffic 10000 cycles -> scoreboard: no loss, no reorder, XOFF/XON strictly alternate.
